store_unit: RTL

Store-path counterpart to the writeback load extender. It accepts one store (SB/SH/SW) from the execute stage and aligns the register data into the byte lanes of the 32-bit data-memory word. It drives a byte-enabled write to data memory over a req/ack handshake and splits misaligned stores into two word writes. It stalls the pipeline through `st_ready` until the store has completed.

---
 rtl/store_unit_pkg.sv | 26 ++
 rtl/store_align.sv | 31 +++
 rtl/store_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/store_unit_pkg.sv
// Shared CPU encodings and store-path types.
package store_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  // Load funct3 encodings (writeback extender)
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // One data-memory write beat
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [BE_W-1:0] be;
  } mem_beat_t;

endpackage

// File: rtl/store_align.sv
// Combinational lane aligner: (funct3, offset, data) -> 8-lane mask and 64-bit shifted data.
module store_align
  import store_unit_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        off,
  input  logic [XLEN-1:0]   data,
  output logic [2*BE_W-1:0] m8,
  output logic [2*XLEN-1:0] d64,
  output logic              legal
);

  logic [BE_W-1:0] mask4;
  logic [XLEN-1:0] dmask;

  // Select width mask and zero the unstored bytes, then shift into lanes
  always_comb begin
    mask4 = '0;
    dmask = '0;
    legal = 1'b1;
    case (funct3)
      SB:      begin mask4 = 4'b0001; dmask = {24'd0, data[7:0]};  end
      SH:      begin mask4 = 4'b0011; dmask = {16'd0, data[15:0]}; end
      SW:      begin mask4 = 4'b1111; dmask = data;                end
      default: legal = 1'b0;
    endcase
    m8  = (2*BE_W)'(mask4) << off;
    d64 = (2*XLEN)'(dmask) << {off, 3'b000};
  end

endmodule

// File: rtl/store_unit.sv
// Store unit: aligns SB/SH/SW data into byte lanes and issues one or two
// byte-enabled word writes over a req/ack handshake.
module store_unit
  import store_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            st_valid,
  output logic            st_ready,
  input  logic [XLEN-1:0] st_addr,
  input  logic [XLEN-1:0] st_data,
  input  logic [2:0]      st_funct3,
  output logic            st_done,
  output logic            st_err,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [BE_W-1:0] mem_be,
  input  logic            mem_ack
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  state_t          state, state_n;
  mem_beat_t       beat_q, beat_n;
  logic [BE_W-1:0] hi_be_q, hi_be_n;
  logic [XLEN-1:0] hi_wdata_q, hi_wdata_n;
  logic            req_q, req_n;
  logic            done_q, done_n;
  logic            err_q, err_n;

  logic [2*BE_W-1:0] m8;
  logic [2*XLEN-1:0] d64;
  logic              legal;

  store_align u_align (
    .funct3 (st_funct3),
    .off    (st_addr[1:0]),
    .data   (st_data),
    .m8     (m8),
    .d64    (d64),
    .legal  (legal)
  );

  // Next-state and next-output decode
  always_comb begin
    state_n    = state;
    beat_n     = beat_q;
    hi_be_n    = hi_be_q;
    hi_wdata_n = hi_wdata_q;
    req_n      = req_q;
    done_n     = 1'b0;
    err_n      = 1'b0;
    case (state)
      IDLE: begin
        req_n = 1'b0;
        if (st_valid) begin
          if (!legal) begin
            err_n = 1'b1;
          end else begin
            state_n      = BEAT0;
            req_n        = 1'b1;
            beat_n.addr  = {st_addr[XLEN-1:2], 2'b00};
            beat_n.be    = m8[BE_W-1:0];
            beat_n.wdata = d64[XLEN-1:0];
            hi_be_n      = m8[2*BE_W-1:BE_W];
            hi_wdata_n   = d64[2*XLEN-1:XLEN];
          end
        end
      end
      BEAT0: begin
        if (mem_ack) begin
          if (hi_be_q != '0) begin
            // Second word follows immediately; address wraps mod 2^32
            state_n      = BEAT1;
            beat_n.addr  = beat_q.addr + XLEN'(4);
            beat_n.be    = hi_be_q;
            beat_n.wdata = hi_wdata_q;
          end else begin
            state_n = IDLE;
            req_n   = 1'b0;
            done_n  = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (mem_ack) begin
          state_n = IDLE;
          req_n   = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        req_n   = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beat_q     <= '0;
      hi_be_q    <= '0;
      hi_wdata_q <= '0;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_n;
      beat_q     <= beat_n;
      hi_be_q    <= hi_be_n;
      hi_wdata_q <= hi_wdata_n;
      req_q      <= req_n;
      done_q     <= done_n;
      err_q      <= err_n;
    end
  end

  assign st_ready  = (state == IDLE);
  assign st_done   = done_q;
  assign st_err    = err_q;
  assign mem_req   = req_q;
  assign mem_addr  = beat_q.addr;
  assign mem_wdata = beat_q.wdata;
  assign mem_be    = beat_q.be;

endmodule
